// File: rtl/pll_reconfig_ctrl.sv
// rtl/pll_reconfig_ctrl.sv - rPLL bring-up, lock qualification and runtime divider reconfiguration
// Runs on the PLL reference clock; every output is a flop.
module pll_reconfig_ctrl #(
  parameter int         RESET_CYCLES  = 16,
  parameter int         LOCK_TIMEOUT  = 27000,
  parameter int         STABLE_CYCLES = 256,
  parameter int         MAX_RETRIES   = 3,
  parameter logic [5:0] DEF_IDIV      = 6'd4,
  parameter logic [5:0] DEF_FBDIV     = 6'd36,
  parameter logic [5:0] DEF_ODIV      = 6'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cfg_req,
  input  logic [5:0] cfg_idiv,
  input  logic [5:0] cfg_fbdiv,
  input  logic [5:0] cfg_odiv,
  output logic       cfg_ack,
  output logic       cfg_busy,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       clk_ready,
  output logic       sys_rst_n,
  output logic       err
);

  localparam int MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CW    = $clog2(MAX_P) + 1;
  localparam int RW    = $clog2(MAX_RETRIES) + 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  // The WLOCK cycle that first sees lock_s already counts as one stable cycle.
  localparam logic [CW-1:0] STB_LAST  = CW'((STABLE_CYCLES >= 2) ? (STABLE_CYCLES - 2) : 0);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_SAT = '1;

  typedef enum logic [2:0] {ST_PRST, ST_WLOCK, ST_STABLE, ST_RUN, ST_FAIL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic          lock_m_q, lock_m_d, lock_s_q, lock_s_d;
  logic          pll_reset_q, pll_reset_d;
  logic [5:0]    idsel_q, idsel_d, fbdsel_q, fbdsel_d, odsel_q, odsel_d;
  logic          cfg_ack_q, cfg_ack_d, cfg_busy_q, cfg_busy_d;
  logic          clk_ready_q, clk_ready_d, sys_rst_n_q, sys_rst_n_d, err_q, err_d;
  logic          accept;

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign retry_inc = (retry_q == RETRY_SAT) ? retry_q : retry_q + 1'b1;
  assign accept    = cfg_req && ((state_q == ST_RUN) || (state_q == ST_FAIL));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_m_d    = pll_lock;
    lock_s_d    = lock_m_q;
    pll_reset_d = pll_reset_q;
    idsel_d     = idsel_q;
    fbdsel_d    = fbdsel_q;
    odsel_d     = odsel_q;
    cfg_ack_d   = 1'b0;
    cfg_busy_d  = cfg_busy_q;
    clk_ready_d = clk_ready_q;
    sys_rst_n_d = sys_rst_n_q;
    err_d       = err_q;

    case (state_q)
      ST_PRST: begin
        pll_reset_d = 1'b1;
        if (cnt_q >= RST_LAST) begin
          state_d     = ST_WLOCK;
          pll_reset_d = 1'b0;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WLOCK: begin
        if (lock_s_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q >= TO_LAST) begin
          retry_d     = retry_inc;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          if (retry_inc >= RETRY_MAX) begin
            state_d    = ST_FAIL;
            err_d      = 1'b1;
            cfg_busy_d = 1'b0;
          end else begin
            state_d = ST_PRST;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_STABLE: begin
        if (!lock_s_q) begin
          state_d = ST_WLOCK;
          cnt_d   = '0;
        end else if (cnt_q >= STB_LAST) begin
          state_d     = ST_RUN;
          cnt_d       = '0;
          retry_d     = '0;
          clk_ready_d = 1'b1;
          sys_rst_n_d = 1'b1;
          cfg_busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d     = ST_PRST;
          cnt_d       = '0;
          retry_d     = '0;
          pll_reset_d = 1'b1;
          clk_ready_d = 1'b0;
          sys_rst_n_d = 1'b0;
          cfg_busy_d  = 1'b1;
        end
      end
      ST_FAIL: begin
        pll_reset_d = 1'b1;
      end
      default: begin
        state_d     = ST_PRST;
        cnt_d       = '0;
        pll_reset_d = 1'b1;
      end
    endcase

    // A request wins over a simultaneous lock loss; selects move only as pll_reset rises.
    if (accept) begin
      state_d     = ST_PRST;
      cnt_d       = '0;
      retry_d     = '0;
      pll_reset_d = 1'b1;
      idsel_d     = ~cfg_idiv;
      fbdsel_d    = ~cfg_fbdiv;
      odsel_d     = ~cfg_odiv;
      cfg_ack_d   = 1'b1;
      cfg_busy_d  = 1'b1;
      clk_ready_d = 1'b0;
      sys_rst_n_d = 1'b0;
      err_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PRST;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_m_q    <= 1'b0;
      lock_s_q    <= 1'b0;
      pll_reset_q <= 1'b1;
      idsel_q     <= ~DEF_IDIV;
      fbdsel_q    <= ~DEF_FBDIV;
      odsel_q     <= ~DEF_ODIV;
      cfg_ack_q   <= 1'b0;
      cfg_busy_q  <= 1'b1;
      clk_ready_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_m_q    <= lock_m_d;
      lock_s_q    <= lock_s_d;
      pll_reset_q <= pll_reset_d;
      idsel_q     <= idsel_d;
      fbdsel_q    <= fbdsel_d;
      odsel_q     <= odsel_d;
      cfg_ack_q   <= cfg_ack_d;
      cfg_busy_q  <= cfg_busy_d;
      clk_ready_q <= clk_ready_d;
      sys_rst_n_q <= sys_rst_n_d;
      err_q       <= err_d;
    end
  end

  assign pll_reset  = pll_reset_q;
  assign pll_idsel  = idsel_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_odsel  = odsel_q;
  assign cfg_ack    = cfg_ack_q;
  assign cfg_busy   = cfg_busy_q;
  assign clk_ready  = clk_ready_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign err        = err_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// tb/tb_pll_reconfig_ctrl.sv - directed bench for pll_reconfig_ctrl with a behavioural PLL lock model
module tb_pll_reconfig_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_req = 1'b0;
  logic [5:0] cfg_idiv = 6'd0, cfg_fbdiv = 6'd0, cfg_odiv = 6'd0;
  logic       cfg_ack, cfg_busy, pll_lock, pll_reset, clk_ready, sys_rst_n, err;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;

  logic model_lock = 1'b0;
  logic lock_en = 1'b0;
  logic glitch = 1'b0;
  int   rel_cnt = 0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  assign pll_lock = model_lock & ~glitch;

  pll_reconfig_ctrl #(
    .RESET_CYCLES(4), .LOCK_TIMEOUT(20), .STABLE_CYCLES(8), .MAX_RETRIES(2),
    .DEF_IDIV(6'd4), .DEF_FBDIV(6'd36), .DEF_ODIV(6'd4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_req(cfg_req),
    .cfg_idiv(cfg_idiv), .cfg_fbdiv(cfg_fbdiv), .cfg_odiv(cfg_odiv),
    .cfg_ack(cfg_ack), .cfg_busy(cfg_busy), .pll_lock(pll_lock), .pll_reset(pll_reset),
    .pll_idsel(pll_idsel), .pll_fbdsel(pll_fbdsel), .pll_odsel(pll_odsel),
    .clk_ready(clk_ready), .sys_rst_n(sys_rst_n), .err(err)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // PLL model: lock rises 10 cycles after RESET is released, drops as soon as RESET is seen.
  initial forever begin
    @(posedge clk);
    #1;
    if (pll_reset !== 1'b0 || !lock_en) begin
      rel_cnt    = 0;
      model_lock = 1'b0;
    end else begin
      if (rel_cnt < 100) rel_cnt++;
      if (rel_cnt > 10) model_lock = 1'b1;
    end
  end

  function automatic logic sig(input int id);
    case (id)
      0:       return pll_reset;
      1:       return clk_ready;
      2:       return pll_lock;
      3:       return err;
      default: return cfg_ack;
    endcase
  endfunction

  task automatic wait_sig(input int id, input logic val, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sig(id) === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset_pll_reset: got %b expected 1", pll_reset); end
    n_checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'h3B, 6'h1B, 6'h3B}) begin n_fail++; $display("FAIL reset_selects: got %h/%h/%h expected 3b/1b/3b", pll_idsel, pll_fbdsel, pll_odsel); end
    n_checks++; if ({cfg_ack, cfg_busy, clk_ready, sys_rst_n, err} !== 5'b01000) begin n_fail++; $display("FAIL reset_flags: got ack/busy/rdy/srst/err=%b expected 01000", {cfg_ack, cfg_busy, clk_ready, sys_rst_n, err}); end
  endtask

  task automatic test_nominal();
    int hi, fall_cyc, at;
    lock_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (pll_reset !== 1'b1) break;
      hi++;
      @(negedge clk);
    end
    fall_cyc = cyc;
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL nom_reset_width: got %0d expected 4", hi); end
    n_checks++; if ({pll_idsel, pll_fbdsel} !== {6'h3B, 6'h1B}) begin n_fail++; $display("FAIL nom_selects: got %h/%h expected 3b/1b", pll_idsel, pll_fbdsel); end
    n_checks++; if (cfg_busy !== 1'b1) begin n_fail++; $display("FAIL nom_busy_before: got %b expected 1", cfg_busy); end
    wait_sig(1, 1'b1, 100, at);
    n_checks++; if (at - fall_cyc != 20) begin n_fail++; $display("FAIL nom_ready_latency: got %0d expected 20", at - fall_cyc); end
    n_checks++; if ({sys_rst_n, cfg_busy} !== 2'b10) begin n_fail++; $display("FAIL nom_ready_flags: got srst/busy=%b expected 10", {sys_rst_n, cfg_busy}); end
  endtask

  task automatic test_lock_glitch();
    int l_cyc, at, hi, fall_cyc;
    apply_reset();
    wait_sig(2, 1'b1, 100, l_cyc);
    repeat (3) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
    wait_sig(1, 1'b1, 100, at);
    n_checks++; if (l_cyc < 0 || at != l_cyc + 14) begin n_fail++; $display("FAIL glitch_stable_restart: got ready at %0d expected %0d", at, l_cyc + 14); end
    @(negedge clk);
    glitch = 1'b1;
    at = -1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (clk_ready === 1'b0) begin at = i + 1; break; end
    end
    n_checks++; if (at < 0) begin n_fail++; $display("FAIL glitch_run_drop: clk_ready still %b after 3 cycles, expected 0", clk_ready); end
    n_checks++; if (sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL glitch_run_srst: got %b expected 0", sys_rst_n); end
    glitch = 1'b0;
    hi = 0;
    for (int i = 0; i < 50; i++) begin
      if (pll_reset !== 1'b1) break;
      hi++;
      @(negedge clk);
    end
    fall_cyc = cyc;
    n_checks++; if (hi != 4) begin n_fail++; $display("FAIL glitch_reset_pulse: got %0d expected 4", hi); end
    wait_sig(1, 1'b1, 100, at);
    n_checks++; if (at - fall_cyc != 20) begin n_fail++; $display("FAIL glitch_relock: got %0d expected 20", at - fall_cyc); end
  endtask

  task automatic test_timeout();
    int at, lo1, lo2;
    lock_en = 1'b0;
    apply_reset();
    wait_sig(0, 1'b0, 50, at);
    lo1 = 0;
    while (pll_reset === 1'b0 && lo1 < 100) begin lo1++; @(negedge clk); end
    n_checks++; if (lo1 != 20) begin n_fail++; $display("FAIL to_wait1: got %0d expected 20", lo1); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_early: got %b expected 0", err); end
    wait_sig(0, 1'b0, 50, at);
    lo2 = 0;
    while (pll_reset === 1'b0 && lo2 < 100) begin lo2++; @(negedge clk); end
    n_checks++; if (lo2 != 20) begin n_fail++; $display("FAIL to_wait2: got %0d expected 20", lo2); end
    n_checks++; if ({err, pll_reset, cfg_busy} !== 3'b110) begin n_fail++; $display("FAIL to_fail_flags: got err/rst/busy=%b expected 110", {err, pll_reset, cfg_busy}); end
    repeat (30) @(negedge clk);
    n_checks++; if ({err, pll_reset, clk_ready} !== 3'b110) begin n_fail++; $display("FAIL to_sticky: got err/rst/rdy=%b expected 110", {err, pll_reset, clk_ready}); end
    lock_en   = 1'b1;
    cfg_idiv  = 6'd4;
    cfg_fbdiv = 6'd36;
    cfg_odiv  = 6'd4;
    cfg_req   = 1'b1;
    wait_sig(4, 1'b1, 5, at);
    cfg_req = 1'b0;
    n_checks++; if (at < 0 || err !== 1'b0 || cfg_busy !== 1'b1) begin n_fail++; $display("FAIL to_fail_exit: ack_at=%0d err=%b busy=%b expected ack, err 0, busy 1", at, err, cfg_busy); end
    wait_sig(1, 1'b1, 100, at);
    n_checks++; if (at < 0) begin n_fail++; $display("FAIL to_recover: clk_ready=%b expected 1", clk_ready); end
  endtask

  task automatic test_reconfig();
    int at;
    @(negedge clk);
    n_checks++; if ({clk_ready, pll_reset} !== 2'b10) begin n_fail++; $display("FAIL rc_pre_run: got rdy/rst=%b expected 10", {clk_ready, pll_reset}); end
    cfg_idiv  = 6'd2;
    cfg_fbdiv = 6'd9;
    cfg_odiv  = 6'd8;
    cfg_req   = 1'b1;
    @(negedge clk);
    cfg_req = 1'b0;
    n_checks++; if ({cfg_ack, pll_reset, cfg_busy, clk_ready} !== 4'b1110) begin n_fail++; $display("FAIL rc_accept: got ack/rst/busy/rdy=%b expected 1110", {cfg_ack, pll_reset, cfg_busy, clk_ready}); end
    n_checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'h3D, 6'h36, 6'h37}) begin n_fail++; $display("FAIL rc_selects: got %h/%h/%h expected 3d/36/37", pll_idsel, pll_fbdsel, pll_odsel); end
    @(negedge clk);
    n_checks++; if (cfg_ack !== 1'b0) begin n_fail++; $display("FAIL rc_ack_pulse: got %b expected 0", cfg_ack); end
    wait_sig(1, 1'b1, 100, at);
    n_checks++; if (at < 0 || pll_idsel !== 6'h3D) begin n_fail++; $display("FAIL rc_relock: ready_at=%0d idsel=%h expected ready, 3d", at, pll_idsel); end
  endtask

  task automatic test_ignored_and_abort();
    int at, early, l_cyc;
    apply_reset();
    wait_sig(0, 1'b0, 50, at);
    cfg_idiv  = 6'd5;
    cfg_fbdiv = 6'd10;
    cfg_odiv  = 6'd2;
    cfg_req   = 1'b1;
    early = 0;
    at = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (clk_ready === 1'b1) begin at = cyc; break; end
      if (cfg_ack !== 1'b0 || pll_idsel !== 6'h3B) early++;
    end
    n_checks++; if (early != 0 || at < 0) begin n_fail++; $display("FAIL ign_early_ack: got %0d early events, ready_at=%0d expected 0 and ready", early, at); end
    @(negedge clk);
    cfg_req = 1'b0;
    n_checks++; if ({cfg_ack, pll_idsel, pll_fbdsel, pll_odsel} !== {1'b1, 6'h3A, 6'h35, 6'h3D}) begin n_fail++; $display("FAIL ign_run_ack: got ack=%b %h/%h/%h expected 1 3a/35/3d", cfg_ack, pll_idsel, pll_fbdsel, pll_odsel); end
    wait_sig(2, 1'b1, 100, l_cyc);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({pll_idsel, pll_fbdsel, pll_odsel} !== {6'h3B, 6'h1B, 6'h3B}) begin n_fail++; $display("FAIL abort_selects: got %h/%h/%h expected 3b/1b/3b", pll_idsel, pll_fbdsel, pll_odsel); end
    n_checks++; if ({pll_reset, cfg_ack, cfg_busy, clk_ready, sys_rst_n, err} !== 6'b101000) begin n_fail++; $display("FAIL abort_flags: got rst/ack/busy/rdy/srst/err=%b expected 101000", {pll_reset, cfg_ack, cfg_busy, clk_ready, sys_rst_n, err}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_timeout();
    test_reconfig();
    test_ignored_and_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
